block_draw_ctrl: RTL
====================

Name: block_draw_ctrl

Overview:
Sequencer for the 4x4 square-plot datapath in the block-stacker display path. It accepts one move request: optionally erase the square at the old position, then draw it at the new position. It drives the datapath's counter clear, count enable, base coordinates and colour, and asserts the VGA write strobe for every emitted pixel. It sits between the game-logic FSM (requester) and the square datapath/VGA adapter.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
BG_COLOUR, 3'b000, colour used for erase pass
PIX_PER_BLOCK, 16, pixels per square (4x4); watchdog limit

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  move request valid
req_ready  out  1  controller idle, can accept
req_erase  in  1  1 = erase old square before drawing
old_x  in  X_W  old square top-left x
old_y  in  Y_W  old square top-left y
new_x  in  X_W  new square top-left x
new_y  in  Y_W  new square top-left y
new_colour  in  C_W  draw colour
dp_clear  out  1  active-high clear of datapath counters (drive datapath resetn = ~dp_clear)
dp_count_en  out  1  datapath count_x_enable
dp_x  out  X_W  base x to datapath
dp_y  out  Y_W  base y to datapath
dp_colour  out  C_W  colour to datapath
dp_done  in  1  datapath done_plot (last pixel of square on this cycle)
plot  out  1  VGA write enable, qualifies datapath x/y/colour outputs
done  out  1  one-cycle pulse, request complete
err  out  1  sticky watchdog error

Behaviour:
- Reset (any cycle, incl. mid-pass): state IDLE; req_ready=0 during reset cycle, 1 after; dp_clear=1, dp_count_en=0, plot=0, done=0, err=0, captured regs=0. Partial square is abandoned, not completed.
- Handshake: accept when req_valid && req_ready at rising edge. req_ready=1 only in IDLE. All request fields captured at accept; later input changes ignored until next accept.
- States: IDLE, CLR_E, ERASE, CLR_D, DRAW, DONE.
- IDLE: dp_clear=1, outputs quiet. On accept -> CLR_E if req_erase else CLR_D.
- CLR_E / CLR_D: one cycle, dp_clear=1, dp_count_en=0, plot=0; dp_x/dp_y/dp_colour already show the coming pass's values. Next ERASE / DRAW.
- ERASE: dp_x/dp_y=captured old, dp_colour=BG_COLOUR, dp_count_en=1, plot=1. DRAW: same with captured new and new_colour.
- Pass exit: when dp_done=1 in ERASE -> CLR_D; in DRAW -> DONE. plot stays 1 on the dp_done cycle (pixel 3,3 written). Exactly 16 plot cycles per pass.
- DONE: done=1 for one cycle, plot=0, dp_clear=1; next IDLE.
- Timing (accept edge = T): with erase, CLR_E T+1, ERASE T+2..T+17, CLR_D T+18, DRAW T+19..T+34, DONE T+35, req_ready=1 at T+36. Without erase, CLR_D T+1, DRAW T+2..T+17, DONE T+18, ready T+19.
- Watchdog: 5-bit pixel counter cleared in CLR_*, incremented each plot cycle. If counter reaches PIX_PER_BLOCK with dp_done never seen, set err (sticky until reset) and exit the pass as if dp_done; plot count still capped at 16. dp_done outside ERASE/DRAW is ignored.
- old==new with req_erase=1: both passes still run; final frame shows drawn colour.
- No arithmetic on coordinates here; datapath adds offsets. Coordinate wrap at screen edge is the requester's responsibility.

Decomposition:
- Package blk_pkg: state enum (IDLE..DONE), X_W/Y_W/C_W, BG_COLOUR, PIX_PER_BLOCK.
- One natural sub-module: pix_watchdog (counter, clear, inc, timeout flag). FSM and capture registers in block_draw_ctrl.

Test Plan:
- Reset, then move req old=(10,20) new=(10,24) colour=3'b101, erase=1 -> ready low T..T+35; 16 plot cycles with dp_x=10,dp_y=20,colour=0; 1 gap; 16 with y=24,colour=5; done at T+35 only.
- req_erase=0, new=(0,0) colour=3'b111 -> CLR_D at T+1, 16 plot cycles, done at T+18, no BG-colour plot.
- Change new_x/new_colour and hold req_valid=1 while busy -> drawn values equal captured; second request accepted at first ready cycle after DONE.
- Assert reset at 7th ERASE plot cycle -> next cycle plot=0, dp_clear=1, state IDLE, no done; following request completes normally.
- Datapath model with dp_done tied 0 -> pass ends after 16 plot cycles, err=1 and stays 1 through later requests until reset.
- Spurious dp_done pulse in IDLE/CLR_D -> ignored; pixel count per pass stays 16.

Source files
------------

// File: rtl/blk_pkg.sv
// Shared types and constants for the square-plot sequencer.
package blk_pkg;

  localparam int unsigned X_W           = 8;
  localparam int unsigned Y_W           = 7;
  localparam int unsigned C_W           = 3;
  localparam logic [C_W-1:0] BG_COLOUR  = 3'b000;
  localparam int unsigned PIX_PER_BLOCK = 16;
  // Wide enough to hold PIX_PER_BLOCK itself.
  localparam int unsigned WDOG_W        = 5;

  typedef enum logic [2:0] {
    StIdle,
    StClrE,
    StErase,
    StClrD,
    StDraw,
    StDone
  } state_e;

endpackage

// File: rtl/block_draw_ctrl_if.sv
// Request and datapath signals of the square-plot sequencer.
// master: requester/datapath side; slave: the sequencer.
interface block_draw_ctrl_if;
  import blk_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_erase;
  logic [X_W-1:0]   old_x;
  logic [Y_W-1:0]   old_y;
  logic [X_W-1:0]   new_x;
  logic [Y_W-1:0]   new_y;
  logic [C_W-1:0]   new_colour;
  logic             dp_clear;
  logic             dp_count_en;
  logic [X_W-1:0]   dp_x;
  logic [Y_W-1:0]   dp_y;
  logic [C_W-1:0]   dp_colour;
  logic             dp_done;
  logic             plot;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_erase, old_x, old_y, new_x, new_y, new_colour, dp_done,
    input  req_ready, dp_clear, dp_count_en, dp_x, dp_y, dp_colour, plot, done, err
  );

  modport slave (
    input  req_valid, req_erase, old_x, old_y, new_x, new_y, new_colour, dp_done,
    output req_ready, dp_clear, dp_count_en, dp_x, dp_y, dp_colour, plot, done, err
  );

endinterface

// File: rtl/pix_watchdog.sv
// Counts plotted pixels in a pass; flags the last allowed pixel so a
// datapath that never reports done cannot hang the sequencer.
module pix_watchdog
  import blk_pkg::*;
#(
  parameter int unsigned Limit = PIX_PER_BLOCK
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High on the plot cycle that brings the count to Limit.
  assign last_o = inc_i && (cnt_q == WDOG_W'(Limit - 1));

endmodule

// File: rtl/block_draw_ctrl.sv
// Square-plot sequencer: optional erase pass at the old position, then a
// draw pass at the new position, each driving the 4x4 datapath.
module block_draw_ctrl
  import blk_pkg::*;
(
  input logic              clk,
  input logic              reset,
  block_draw_ctrl_if.slave bus
);

  state_e state_q, state_d;

  logic [X_W-1:0] old_x_q, new_x_q;
  logic [Y_W-1:0] old_y_q, new_y_q;
  logic [C_W-1:0] new_colour_q;
  logic           err_q;

  logic           accept;
  logic           wd_clear, wd_inc, wd_last;
  logic           err_set;

  logic           dp_clear, dp_count_en, plot, done;
  logic [X_W-1:0] dp_x;
  logic [Y_W-1:0] dp_y;
  logic [C_W-1:0] dp_colour;

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  pix_watchdog #(
    .Limit (PIX_PER_BLOCK)
  ) u_pix_watchdog (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (wd_clear),
    .inc_i   (wd_inc),
    .last_o  (wd_last)
  );

  // Next state and datapath controls.
  always_comb begin
    state_d     = state_q;
    dp_clear    = 1'b1;
    dp_count_en = 1'b0;
    plot        = 1'b0;
    done        = 1'b0;
    dp_x        = new_x_q;
    dp_y        = new_y_q;
    dp_colour   = new_colour_q;
    wd_clear    = 1'b0;
    wd_inc      = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = bus.req_erase ? StClrE : StClrD;
        end
      end
      StClrE: begin
        dp_x      = old_x_q;
        dp_y      = old_y_q;
        dp_colour = BG_COLOUR;
        wd_clear  = 1'b1;
        state_d   = StErase;
      end
      StErase: begin
        dp_x        = old_x_q;
        dp_y        = old_y_q;
        dp_colour   = BG_COLOUR;
        dp_clear    = 1'b0;
        dp_count_en = 1'b1;
        plot        = 1'b1;
        wd_inc      = 1'b1;
        if (bus.dp_done || wd_last) begin
          err_set = !bus.dp_done;
          state_d = StClrD;
        end
      end
      StClrD: begin
        wd_clear = 1'b1;
        state_d  = StDraw;
      end
      StDraw: begin
        dp_clear    = 1'b0;
        dp_count_en = 1'b1;
        plot        = 1'b1;
        wd_inc      = 1'b1;
        if (bus.dp_done || wd_last) begin
          err_set = !bus.dp_done;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A reset cycle abandons any pass immediately.
    if (reset) begin
      dp_clear    = 1'b1;
      dp_count_en = 1'b0;
      plot        = 1'b0;
      done        = 1'b0;
      err_set     = 1'b0;
    end
  end

  // State, request capture and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      old_x_q      <= '0;
      old_y_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        old_x_q      <= bus.old_x;
        old_y_q      <= bus.old_y;
        new_x_q      <= bus.new_x;
        new_y_q      <= bus.new_y;
        new_colour_q <= bus.new_colour;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.dp_clear    = dp_clear;
  assign bus.dp_count_en = dp_count_en;
  assign bus.dp_x        = dp_x;
  assign bus.dp_y        = dp_y;
  assign bus.dp_colour   = dp_colour;
  assign bus.plot        = plot;
  assign bus.done        = done;
  assign bus.err         = err_q;

endmodule
